// File: rtl/wave_gen_if.sv
// rtl/wave_gen_if.sv - control/sample bundle between the DAC sequencer and wave_gen
interface wave_gen_if #(
    parameter int ACC_WIDTH = 24
);
    logic                 next;
    logic [1:0]           wave_sel;
    logic [ACC_WIDTH-1:0] step;
    logic [7:0]           amp;
    logic                 phase_clr;
    logic [11:0]          value;
    logic                 valid;
    logic                 done;
    logic                 busy;
    logic                 overrun;

    // Sequencer side: issues strobes and settings, consumes samples
    modport master (
        output next, wave_sel, step, amp, phase_clr,
        input  value, valid, done, busy, overrun
    );

    // Generator side
    modport slave (
        input  next, wave_sel, step, amp, phase_clr,
        output value, valid, done, busy, overrun
    );
endinterface

// File: rtl/wave_gen.sv
// rtl/wave_gen.sv - phase-accumulator waveform generator with three-cycle sample pipeline
module wave_gen #(
    parameter int ACC_WIDTH = 24
) (
    input  logic       clk,
    input  logic       rst,
    wave_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHAPE = 2'd1,
        SCALE = 2'd2
    } state_t;

    localparam logic [1:0] SEL_SQUARE = 2'b00;
    localparam logic [1:0] SEL_TRI    = 2'b01;
    localparam logic [1:0] SEL_SAW    = 2'b10;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [1:0]           sel_q, sel_d;
    logic [7:0]           amp_q, amp_d;
    logic [11:0]          raw_q, raw_d;
    logic [11:0]          value_q, value_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;

    logic [11:0]          phase;
    logic [11:0]          tri_ramp;
    logic [11:0]          shape_raw;
    logic [20:0]          product;
    logic                 unused_product_bits;

    assign phase    = acc_q[ACC_WIDTH-1 -: 12];
    assign tri_ramp = {phase[10:0], 1'b0};

    // Waveform lookup from the phase index using the selection latched at sample start
    always_comb begin
        shape_raw = 12'hFFF;
        case (sel_q)
            SEL_SQUARE: shape_raw = phase[11] ? 12'h000 : 12'hFFF;
            SEL_TRI:    shape_raw = phase[11] ? ~tri_ramp : tri_ramp;
            SEL_SAW:    shape_raw = phase;
            default:    shape_raw = 12'hFFF;
        endcase
    end

    // amp+1 makes 255 a unity gain, so the top 12 of the low 20 product bits are the result
    assign product             = 21'(raw_q) * 21'({1'b0, amp_q} + 9'd1);
    assign unused_product_bits = &{1'b0, product[20], product[7:0]};

    // Next-state and datapath updates; phase_clr overrides any accumulator step
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sel_d     = sel_q;
        amp_d     = amp_q;
        raw_d     = raw_q;
        value_d   = value_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (bus.next) begin
                    state_d = SHAPE;
                    acc_d   = acc_q + bus.step;
                    sel_d   = bus.wave_sel;
                    amp_d   = bus.amp;
                end
            end
            SHAPE: begin
                state_d = SCALE;
                raw_d   = shape_raw;
            end
            SCALE: begin
                state_d = IDLE;
                value_d = product[19:8];
                valid_d = 1'b1;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (bus.next && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
        if (bus.phase_clr) begin
            acc_d = '0;
        end
    end

    // State register; reset aborts any in-flight sample
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            sel_q     <= 2'b00;
            amp_q     <= 8'd0;
            raw_q     <= 12'd0;
            value_q   <= 12'd0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sel_q     <= sel_d;
            amp_q     <= amp_d;
            raw_q     <= raw_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.value   = value_q;
    assign bus.valid   = valid_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_wave_gen.sv
// tb/tb_wave_gen.sv - directed self-checking bench for wave_gen
module tb_wave_gen;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    wave_gen_if #(.ACC_WIDTH(24)) bus ();

    wave_gen #(.ACC_WIDTH(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.next      = 1'b1;
        bus.phase_clr = 1'b0;
        tick();
        tick();
        rst      = 1'b0;
        bus.next = 1'b0;
    endtask

    task automatic pulse();
        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if (bus.value !== 12'd0) begin n_fail++; $display("FAIL reset_value got %0d exp 0", bus.value); end
        n_checks++;
        if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.valid); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done); end
        n_checks++;
        if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", bus.overrun); end
        n_checks++;
    endtask

    task automatic test_sawtooth();
        int exp_v;
        do_reset();
        bus.wave_sel = 2'b10;
        bus.step     = 24'h100000;
        bus.amp      = 8'd255;
        for (int k = 1; k <= 16; k++) begin
            exp_v = (k * 256) % 4096;
            pulse();
            tick();
            if (bus.done !== 1'b0) begin n_fail++; $display("FAIL saw_done_early k=%0d got %b exp 0", k, bus.done); end
            n_checks++;
            tick();
            if (bus.done !== 1'b1) begin n_fail++; $display("FAIL saw_done k=%0d got %b exp 1", k, bus.done); end
            n_checks++;
            if (bus.value !== 12'(exp_v)) begin n_fail++; $display("FAIL saw_value k=%0d got %0d exp %0d", k, bus.value, exp_v); end
            n_checks++;
            tick();
            if (bus.done !== 1'b0) begin n_fail++; $display("FAIL saw_done_width k=%0d got %b exp 0", k, bus.done); end
            n_checks++;
        end
        if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL saw_valid got %b exp 1", bus.valid); end
        n_checks++;
    endtask

    task automatic test_triangle_square();
        do_reset();
        bus.wave_sel = 2'b01;
        bus.step     = 24'h800000;
        bus.amp      = 8'd255;
        pulse();
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL tri_busy got %b exp 1", bus.busy); end
        n_checks++;
        bus.wave_sel = 2'b10;
        bus.amp      = 8'd0;
        tick();
        tick();
        if (bus.value !== 12'd4095) begin n_fail++; $display("FAIL tri_p2048 got %0d exp 4095", bus.value); end
        n_checks++;
        bus.wave_sel = 2'b01;
        bus.amp      = 8'd255;
        pulse();
        tick();
        tick();
        if (bus.value !== 12'd0) begin n_fail++; $display("FAIL tri_p0 got %0d exp 0", bus.value); end
        n_checks++;
        bus.wave_sel = 2'b00;
        bus.amp      = 8'd127;
        pulse();
        tick();
        tick();
        if (bus.value !== 12'd0) begin n_fail++; $display("FAIL sq_p2048 got %0d exp 0", bus.value); end
        n_checks++;
        pulse();
        tick();
        tick();
        if (bus.value !== 12'd2047) begin n_fail++; $display("FAIL sq_p0 got %0d exp 2047", bus.value); end
        n_checks++;
    endtask

    task automatic test_dc();
        do_reset();
        bus.wave_sel = 2'b11;
        bus.step     = 24'h123456;
        bus.amp      = 8'd0;
        pulse();
        tick();
        tick();
        if (bus.value !== 12'd15) begin n_fail++; $display("FAIL dc_amp0 got %0d exp 15", bus.value); end
        n_checks++;
        bus.amp = 8'd255;
        pulse();
        tick();
        tick();
        if (bus.value !== 12'd4095) begin n_fail++; $display("FAIL dc_amp255 got %0d exp 4095", bus.value); end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        int done_cnt;
        do_reset();
        bus.wave_sel = 2'b10;
        bus.step     = 24'h100000;
        bus.amp      = 8'd255;
        bus.next     = 1'b1;
        tick();
        tick();
        bus.next = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.done === 1'b1) done_cnt++;
        end
        if (done_cnt !== 1) begin n_fail++; $display("FAIL b2b_done_count got %0d exp 1", done_cnt); end
        n_checks++;
        if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun got %b exp 1", bus.overrun); end
        n_checks++;
        if (bus.value !== 12'd256) begin n_fail++; $display("FAIL b2b_value got %0d exp 256", bus.value); end
        n_checks++;
        pulse();
        tick();
        tick();
        if (bus.value !== 12'd512) begin n_fail++; $display("FAIL b2b_acc_once got %0d exp 512", bus.value); end
        n_checks++;
        if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun_sticky got %b exp 1", bus.overrun); end
        n_checks++;
        do_reset();
        if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun_clear got %b exp 0", bus.overrun); end
        n_checks++;
    endtask

    task automatic test_abort_and_clr();
        int done_cnt;
        do_reset();
        bus.wave_sel = 2'b10;
        bus.step     = 24'h100000;
        bus.amp      = 8'd255;
        pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done === 1'b1) done_cnt++;
        end
        if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_done got %0d exp 0", done_cnt); end
        n_checks++;
        if (bus.value !== 12'd0) begin n_fail++; $display("FAIL abort_value got %0d exp 0", bus.value); end
        n_checks++;
        if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b exp 0", bus.valid); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
        n_checks++;
        pulse();
        tick();
        tick();
        if (bus.value !== 12'd256) begin n_fail++; $display("FAIL clr_pre got %0d exp 256", bus.value); end
        n_checks++;
        bus.next      = 1'b1;
        bus.phase_clr = 1'b1;
        tick();
        bus.next      = 1'b0;
        bus.phase_clr = 1'b0;
        tick();
        tick();
        if (bus.value !== 12'd0) begin n_fail++; $display("FAIL clr_with_next got %0d exp 0", bus.value); end
        n_checks++;
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL clr_done got %b exp 1", bus.done); end
        n_checks++;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.next      = 1'b0;
        bus.phase_clr = 1'b0;
        bus.wave_sel  = 2'b00;
        bus.step      = 24'd0;
        bus.amp       = 8'd0;
        test_reset();
        test_sawtooth();
        test_triangle_square();
        test_dc();
        test_back_to_back();
        test_abort_and_clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wave_gen.md
WAVE_GEN -- requirements
Module: wave_gen

Interface
REQ-001 Parameter: ACC_WIDTH, default 24, phase accumulator width (>= 12; top 12 bits form the phase index).
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 next  input  1  sample-advance strobe from the DAC sequencer, one cycle wide.
REQ-005 wave_sel  input  2  waveform select: 00 square, 01 triangle, 10 sawtooth, 11 DC.
REQ-006 step  input  ACC_WIDTH  phase increment per sample.
REQ-007 amp  input  8  amplitude scale.
REQ-008 phase_clr  input  1  synchronous phase accumulator clear.
REQ-009 value  output  12  current sample, held stable between updates, consumed by the DAC sequencer.
REQ-010 valid  output  1  high once the first sample has been produced since reset.
REQ-011 done  output  1  one-cycle pulse in the cycle value updates.
REQ-012 busy  output  1  high while a sample is in flight (state != IDLE).
REQ-013 overrun  output  1  sticky flag: a next strobe was dropped.

Function
REQ-014 FSM states IDLE, SHAPE, SCALE; IDLE -> SHAPE on next; SHAPE -> SCALE unconditionally; SCALE -> IDLE unconditionally.
REQ-015 On the edge where next=1 in IDLE: acc <= (acc + step) mod 2^ACC_WIDTH; wave_sel and amp latched; these latched copies are used for the whole sample.
REQ-016 In SHAPE the edge registers raw = f(p), where p = acc[ACC_WIDTH-1 -: 12] after the REQ-015 update.
REQ-017 Square: raw = 4095 if p[11]=0, else 0.
REQ-018 Triangle: raw = {p[10:0],0} if p[11]=0, else bitwise-NOT of {p[10:0],0} (p=0->0, 2047->4094, 2048->4095, 4095->1).
REQ-019 Sawtooth: raw = p.
REQ-020 DC: raw = 4095.
REQ-021 In SCALE the edge registers value = (raw * (amp+1)) >> 8, using a 21-bit unsigned product with no rounding; amp=255 passes raw unchanged, amp=0 gives raw>>8.
REQ-022 The SCALE edge also sets valid=1 and drives done=1 for exactly the following cycle.
REQ-023 Latency: value updates on the 3rd rising edge counting the edge that samples next (value visible 3 cycles after next).
REQ-024 next=1 while busy=1 is ignored: no accumulator change, one sample completes, overrun set to 1.
REQ-025 phase_clr=1 sets acc to 0 on that edge in any state, taking priority over a simultaneous next increment (the FSM still advances on that next); an in-flight raw/value is not altered.
REQ-026 Inputs wave_sel, step, amp changing outside the next edge have no effect on the in-flight sample.
REQ-027 Accumulator wraps silently modulo 2^ACC_WIDTH; no flag.

Reset
REQ-028 rst=1 on an edge: state IDLE, acc=0, raw=0, value=0, valid=0, done=0, busy=0, overrun=0; rst dominates next and phase_clr.
REQ-029 rst asserted mid-sample (SHAPE or SCALE) aborts the sample: no done pulse, value remains 0.

Verification
REQ-030 Reset: hold rst 2 cycles, release -> value=0, valid=0, busy=0, done=0, overrun=0.
REQ-031 Sawtooth, step=2^20, amp=255, 16 next pulses spaced 4 cycles -> value 256, 512, ..., 3840, then 0; done once per pulse, each 3 cycles after next.
REQ-032 Triangle, step=2^23, amp=255: first next -> 4095 (p=2048), second -> 0 (p=0); Square same step, amp=127 -> 0, then 2047.
REQ-033 DC, amp=0 -> value=15; amp=255 -> 4095.
REQ-034 next on two consecutive cycles -> single done, overrun=1 and stays 1 until rst; acc advanced by step once.
REQ-035 rst asserted during SHAPE -> no done; value=0, valid=0; phase_clr with next simultaneously -> sample uses p=0 (sawtooth value 0).
